// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-source round-robin mux arbiter.
// State encoding is fixed at 2 bits: IDLE=0, GRANT=1, RELEASE=2.
package mux8_rr_arbiter_pkg;

    localparam int N_SRC = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    function automatic logic [N_SRC-1:0] onehot8(input logic [SEL_W-1:0] idx);
        return {{(N_SRC-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the 8 requesters and the mux arbiter.
// master = requester side, slave = arbiter side.
interface mux8_rr_arbiter_if;
    import mux8_rr_arbiter_pkg::*;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             timeout;

    modport master (output req, input gnt, sel, valid, timeout);
    modport slave  (input req, output gnt, sel, valid, timeout);

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Latency 0; no backpressure (pure function of req and ptr).
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [2*N_SRC-1:0] dbl;
    logic [N_SRC-1:0]   rot;
    logic [SEL_W-1:0]   off;

    always_comb begin
        dbl = {req, req};
        // Rotating right by ptr puts source ptr at bit 0, so lowest set bit wins.
        rot = N_SRC'(dbl >> ptr);
        off = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        any = |req;
        idx = ptr + off;
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin owner arbiter for a shared 8:1 mux; optional forced release via MUX8_ARB_TIMEOUT_EN.
// Latency: req->gnt 1 cycle; owner drop->gnt low 1 cycle, then a fixed 1-cycle turnaround.
// Backpressure: grant held while owner's req stays high; no preemption, others wait.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD  = 16,
    parameter int RESET_PTR = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    mux8_rr_arbiter_if.slave arb
);

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || RESET_PTR < 0 || RESET_PTR > 7) begin : g_bad_param
        $error("mux8_rr_arbiter: MAX_HOLD must be 2..255 and RESET_PTR 0..7");
    end

    arb_state_e       state_q, state_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             owner_req;

`ifdef MUX8_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
`endif

    rr_pick8 u_pick (
        .req (arb.req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_req = arb.req[sel_q];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
`ifdef MUX8_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    gnt_d   = onehot8(pick_idx);
                    sel_d   = pick_idx;
                    valid_d = 1'b1;
`ifdef MUX8_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_GRANT: begin
                // sel is left alone on release so the mux stays put through turnaround.
                if (!owner_req) begin
                    state_d = ST_RELEASE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 3'd1;
`ifdef MUX8_ARB_TIMEOUT_EN
                end else if (cnt_q == HOLD_LAST) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    ptr_d     = sel_q + 3'd1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
`endif
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            sel_q     <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= SEL_W'(RESET_PTR);
`ifdef MUX8_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
`ifdef MUX8_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign arb.gnt   = gnt_q;
    assign arb.sel   = sel_q;
    assign arb.valid = valid_q;
`ifdef MUX8_ARB_TIMEOUT_EN
    assign arb.timeout = timeout_q;
`else
    assign arb.timeout = 1'b0;
`endif

endmodule
